// File: rtl/shift_deserializer.sv
// -----------------------------------------------------------------------------
// shift_deserializer
//
// Purpose:
//   Full-duplex serial<->parallel shift register with a bit counter and a
//   word handshake. It sits between the external serial program/data loader
//   and the CPU word bus.
//   - Each enabled shift moves one bit in on ser_i and presents the outgoing
//     bit on ser_o.
//   - Every WIDTH-th shift, the completed word is copied into a holding
//     register, and word_valid_o is raised until the consumer acknowledges it.
//   - A parallel preload (load_i) supports transmit.
//
// Parameters:
//   WIDTH      shift/word width in bits (>= 2)
//   MSB_FIRST  1: shift toward the MSB, serial in at bit 0, ser_o = MSB
//              0: shift toward the LSB, serial in at bit WIDTH-1, ser_o = LSB
//   CW         counter width, derived from WIDTH (do not override)
//
// Ports:
//   clk           in   clock; all state updates on the rising edge
//   reset         in   synchronous active-high reset; overrides everything
//   shift_en_i    in   shift one bit this cycle
//   ser_i         in   serial data in, sampled when shift_en_i=1
//   load_i        in   parallel load of par_i (has priority over shift_en_i)
//   par_i         in   parallel load data
//   word_ack_i    in   consumer accepts word_o
//   ser_o         out  current outgoing bit (combinational from the shift reg)
//   shift_o       out  live shift register contents
//   word_o        out  last completed word
//   word_valid_o  out  word_o holds an unacknowledged completed word
//   overflow_o    out  sticky: a completed word overwrote an unacked one
//   count_o       out  bits shifted since the last load/reset/word completion
// -----------------------------------------------------------------------------
module shift_deserializer #(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 1,
    parameter int CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en_i,
    input  logic             ser_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] par_i,
    input  logic             word_ack_i,
    output logic             ser_o,
    output logic [WIDTH-1:0] shift_o,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid_o,
    output logic             overflow_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_word;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic             r_overflow;

    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;
    logic             w_do_shift;
    logic             w_complete;

    // The shift direction is fixed at elaboration time.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {r_shift[WIDTH-2:0], ser_i};
            assign w_out_bit = r_shift[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {ser_i, r_shift[WIDTH-1:1]};
            assign w_out_bit = r_shift[0];
        end
    endgenerate

    // A load pre-empts the shift, so it also suppresses word completion.
    assign w_do_shift = shift_en_i && !load_i;
    assign w_complete = w_do_shift && (r_count == LAST_BIT);

    // Shift register and bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (load_i) begin
            r_shift <= par_i;
            r_count <= '0;
        end else if (shift_en_i) begin
            r_shift <= w_shifted;
            r_count <= w_complete ? '0 : r_count + CW'(1);
        end
    end

    // Holding register and handshake. A completion always wins over an ack
    // in the same cycle: the new word stays valid and is not counted as an
    // overflow, because the previous word was consumed on that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_complete) begin
                r_word  <= w_shifted;
                r_valid <= 1'b1;
                if (r_valid && !word_ack_i) begin
                    r_overflow <= 1'b1;
                end
            end else if (r_valid && word_ack_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ser_o        = w_out_bit;
    assign shift_o      = r_shift;
    assign word_o       = r_word;
    assign word_valid_o = r_valid;
    assign overflow_o   = r_overflow;
    assign count_o      = r_count;

endmodule

// File: tb/tb_shift_deserializer.sv
// -----------------------------------------------------------------------------
// tb_shift_deserializer
//
// Directed testbench for shift_deserializer. It uses two instances: one
// MSB-first and one LSB-first, with WIDTH=16 for both. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_shift_deserializer;

    logic        clk = 1'b0;
    logic        reset;

    // MSB-first instance
    logic        m_shift_en, m_ser_i, m_load, m_ack;
    logic [15:0] m_par;
    logic        m_ser_o, m_valid, m_ovf;
    logic [15:0] m_shift_o, m_word;
    logic [3:0]  m_count;

    // LSB-first instance
    logic        l_shift_en, l_ser_i, l_load, l_ack;
    logic [15:0] l_par;
    logic        l_ser_o, l_valid, l_ovf;
    logic [15:0] l_shift_o, l_word;
    logic [3:0]  l_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_deserializer #(.WIDTH(16), .MSB_FIRST(1)) dut_m (
        .clk          (clk),
        .reset        (reset),
        .shift_en_i   (m_shift_en),
        .ser_i        (m_ser_i),
        .load_i       (m_load),
        .par_i        (m_par),
        .word_ack_i   (m_ack),
        .ser_o        (m_ser_o),
        .shift_o      (m_shift_o),
        .word_o       (m_word),
        .word_valid_o (m_valid),
        .overflow_o   (m_ovf),
        .count_o      (m_count)
    );

    shift_deserializer #(.WIDTH(16), .MSB_FIRST(0)) dut_l (
        .clk          (clk),
        .reset        (reset),
        .shift_en_i   (l_shift_en),
        .ser_i        (l_ser_i),
        .load_i       (l_load),
        .par_i        (l_par),
        .word_ack_i   (l_ack),
        .ser_o        (l_ser_o),
        .shift_o      (l_shift_o),
        .word_o       (l_word),
        .word_valid_o (l_valid),
        .overflow_o   (l_ovf),
        .count_o      (l_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs change 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_shift_en = 0; m_ser_i = 0; m_load = 0; m_ack = 0;
        l_shift_en = 0; l_ser_i = 0; l_load = 0; l_ack = 0;
    endtask

    // Shift one word into the MSB-first instance. The ack is optionally
    // raised on the final (completing) shift.
    task automatic m_shift_word(input logic [15:0] v, input bit ack_last);
        for (int i = 15; i >= 0; i--) begin
            m_shift_en = 1;
            m_ser_i    = v[i];
            m_ack      = ack_last && (i == 0);
            tick();
        end
        m_shift_en = 0; m_ser_i = 0; m_ack = 0;
        $display("[%0t] msb: shifted word %04h -> word_o=%04h valid=%0b ovf=%0b",
                 $time, v, m_word, m_valid, m_ovf);
    endtask

    task automatic m_shifts(input int n);
        for (int i = 0; i < n; i++) begin
            m_shift_en = 1;
            m_ser_i    = i[0];
            tick();
        end
        m_shift_en = 0; m_ser_i = 0;
    endtask

    logic [15:0] seq;

    initial begin
        reset = 1;
        idle_inputs();
        m_par = '0; l_par = '0;
        tick(); tick();
        reset = 0;

        // ---------------- 1. Reset over scrambled state ----------------
        for (int i = 0; i < 40; i++) begin
            m_shift_en = 1'($urandom); m_ser_i = 1'($urandom);
            m_load = ($urandom_range(0, 7) == 0); m_ack = 1'($urandom);
            m_par = 16'($urandom);
            l_shift_en = 1'($urandom); l_ser_i = 1'($urandom);
            l_load = ($urandom_range(0, 7) == 0); l_ack = 1'($urandom);
            l_par = 16'($urandom);
            tick();
        end
        // Reset must override load/shift that are active at the same time.
        m_load = 1; m_shift_en = 1; m_par = 16'hFFFF; m_ser_i = 1;
        l_load = 1; l_shift_en = 1; l_par = 16'hFFFF; l_ser_i = 1;
        reset = 1;
        tick();
        reset = 0;
        idle_inputs();
        $display("[%0t] reset applied", $time);
        chk("rst_m_shift", 32'(m_shift_o), 32'h0);
        chk("rst_m_word",  32'(m_word),    32'h0);
        chk("rst_m_count", 32'(m_count),   32'h0);
        chk("rst_m_valid", 32'(m_valid),   32'h0);
        chk("rst_m_ovf",   32'(m_ovf),     32'h0);
        chk("rst_m_ser",   32'(m_ser_o),   32'h0);
        chk("rst_l_shift", 32'(l_shift_o), 32'h0);
        chk("rst_l_valid", 32'(l_valid),   32'h0);

        // ---------------- 2. MSB-first receive ----------------
        for (int i = 15; i >= 8; i--) begin
            m_shift_en = 1; m_ser_i = (i == 15 || i == 13 || i == 10 || i == 8);
            tick();
        end
        m_shift_en = 0;
        chk("msb_half_count", 32'(m_count), 32'd8);
        chk("msb_half_valid", 32'(m_valid), 32'h0);
        chk("msb_half_shift", 32'(m_shift_o), 32'h00A5);
        for (int i = 7; i >= 0; i--) begin
            m_shift_en = 1; m_ser_i = (i == 7 || i == 6 || i == 1 || i == 0);
            tick();
        end
        m_shift_en = 0; m_ser_i = 0;
        $display("[%0t] msb: received word_o=%04h", $time, m_word);
        chk("msb_word",  32'(m_word),  32'hA5C3);
        chk("msb_valid", 32'(m_valid), 32'h1);
        chk("msb_count", 32'(m_count), 32'h0);
        tick();  // one idle cycle, valid must hold
        chk("msb_valid_hold", 32'(m_valid), 32'h1);
        m_ack = 1;
        tick();
        m_ack = 0;
        $display("[%0t] msb: ack", $time);
        chk("msb_ack_valid", 32'(m_valid), 32'h0);
        chk("msb_ack_word",  32'(m_word),  32'hA5C3);

        // ---------------- 3. Full duplex transmit ----------------
        m_load = 1; m_par = 16'h8001;
        tick();
        m_load = 0;
        chk("dup_load_shift", 32'(m_shift_o), 32'h8001);
        chk("dup_load_count", 32'(m_count),   32'h0);
        chk("dup_word_kept",  32'(m_word),    32'hA5C3);
        seq = '0;
        for (int i = 15; i >= 0; i--) begin
            seq[i] = m_ser_o;  // pre-shift bit
            m_shift_en = 1; m_ser_i = 0;
            tick();
        end
        m_shift_en = 0;
        $display("[%0t] msb: tx sequence %04h word_o=%04h", $time, seq, m_word);
        chk("dup_ser_seq", 32'(seq),     32'h8001);
        chk("dup_word",    32'(m_word),  32'h0000);
        chk("dup_valid",   32'(m_valid), 32'h1);
        chk("dup_ovf",     32'(m_ovf),   32'h0);

        // ---------------- 4. LSB-first instance ----------------
        begin
            logic [15:0] v;
            v = 16'h1234;
            for (int i = 0; i < 16; i++) begin
                l_shift_en = 1; l_ser_i = v[i];
                tick();
            end
        end
        l_shift_en = 0; l_ser_i = 0;
        $display("[%0t] lsb: received word_o=%04h", $time, l_word);
        chk("lsb_word",  32'(l_word),  32'h1234);
        chk("lsb_valid", 32'(l_valid), 32'h1);
        l_ack = 1;
        tick();
        l_ack = 0;
        chk("lsb_ack_valid", 32'(l_valid), 32'h0);
        l_load = 1; l_par = 16'h0003;
        tick();
        l_load = 0;
        seq = '0;
        for (int i = 0; i < 16; i++) begin
            seq[i] = l_ser_o;  // first emitted bit lands in seq[0]
            l_shift_en = 1; l_ser_i = 0;
            tick();
        end
        l_shift_en = 0;
        $display("[%0t] lsb: tx sequence %04h", $time, seq);
        chk("lsb_ser_seq", 32'(seq),    32'h0003);
        chk("lsb_word0",   32'(l_word), 32'h0000);
        chk("lsb_ovf",     32'(l_ovf),  32'h0);

        // ---------------- 5. Overflow ----------------
        m_ack = 1;  // clear the word left from the duplex test
        tick();
        m_ack = 0;
        chk("ovf_pre_valid", 32'(m_valid), 32'h0);
        m_shift_word(16'h1111, 0);
        chk("ovf_w1_word", 32'(m_word), 32'h1111);
        chk("ovf_w1_ovf",  32'(m_ovf),  32'h0);
        m_shift_word(16'h2222, 0);
        chk("ovf_w2_word",  32'(m_word),  32'h2222);
        chk("ovf_w2_valid", 32'(m_valid), 32'h1);
        chk("ovf_w2_ovf",   32'(m_ovf),   32'h1);
        m_shift_word(16'h3333, 1);  // ack coincides with completion
        chk("ovf_w3_word",  32'(m_word),  32'h3333);
        chk("ovf_w3_valid", 32'(m_valid), 32'h1);
        chk("ovf_w3_ovf",   32'(m_ovf),   32'h1);
        m_ack = 1;
        tick();
        m_ack = 0;
        chk("ovf_ack_valid",  32'(m_valid), 32'h0);
        chk("ovf_ack_sticky", 32'(m_ovf),   32'h1);

        // ---------------- 6. Mid-word events ----------------
        m_shifts(7);
        chk("mid_count7", 32'(m_count), 32'd7);
        m_load = 1; m_shift_en = 1; m_ser_i = 1; m_par = 16'hBEEF;
        tick();
        m_load = 0; m_shift_en = 0; m_ser_i = 0;
        $display("[%0t] msb: load during shift", $time);
        chk("mid_load_count", 32'(m_count),   32'h0);
        chk("mid_load_shift", 32'(m_shift_o), 32'hBEEF);
        m_shifts(9);
        chk("mid_count9", 32'(m_count), 32'd9);
        chk("mid_valid9", 32'(m_valid), 32'h0);
        reset = 1;
        tick();
        reset = 0;
        $display("[%0t] reset mid-word", $time);
        chk("mid_rst_count", 32'(m_count),   32'h0);
        chk("mid_rst_valid", 32'(m_valid),   32'h0);
        chk("mid_rst_ovf",   32'(m_ovf),     32'h0);
        chk("mid_rst_shift", 32'(m_shift_o), 32'h0);
        chk("mid_rst_word",  32'(m_word),    32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
